// File: rtl/phys_reg_free_list_ckpt_if.sv
// Rename-stage free-list bus: dispatch alloc, commit free, branch checkpoint control
// and the committed RRF map used on flush.
interface phys_reg_free_list_ckpt_if #(
    parameter int unsigned NUM_PHYS_REG = 64,
    parameter int unsigned NUM_ARCH_REG = 32,
    parameter int unsigned ALLOC_WIDTH  = 2,
    parameter int unsigned FREE_WIDTH   = 2,
    parameter int unsigned NUM_CKPT     = 4
);
    localparam int unsigned PREG_W = $clog2(NUM_PHYS_REG);
    localparam int unsigned CKPT_W = $clog2(NUM_CKPT);

    logic [ALLOC_WIDTH-1:0]         alloc_req;
    logic [ALLOC_WIDTH*PREG_W-1:0]  alloc_preg;
    logic                           alloc_ready;
    logic [FREE_WIDTH-1:0]          free_valid;
    logic [FREE_WIDTH*PREG_W-1:0]   free_preg;
    logic [PREG_W:0]                free_count;
    logic                           ckpt_save;
    logic [CKPT_W-1:0]              ckpt_tag;
    logic                           ckpt_full;
    logic                           ckpt_release;
    logic                           ckpt_restore;
    logic [CKPT_W-1:0]              ckpt_restore_tag;
    logic                           flush;
    logic [NUM_ARCH_REG*PREG_W-1:0] rrf_map;

    modport master (
        output alloc_req, free_valid, free_preg, ckpt_save, ckpt_release,
               ckpt_restore, ckpt_restore_tag, flush, rrf_map,
        input  alloc_preg, alloc_ready, free_count, ckpt_tag, ckpt_full
    );

    modport slave (
        input  alloc_req, free_valid, free_preg, ckpt_save, ckpt_release,
               ckpt_restore, ckpt_restore_tag, flush, rrf_map,
        output alloc_preg, alloc_ready, free_count, ckpt_tag, ckpt_full
    );
endinterface

// File: rtl/phys_reg_free_list_ckpt.sv
// Bitmap physical-register free list with multi-port alloc/free, a ring of branch
// checkpoints for single-cycle mispredict recovery, and RRF-based flush rebuild.
module phys_reg_free_list_ckpt #(
    parameter int unsigned NUM_PHYS_REG = 64,
    parameter int unsigned NUM_ARCH_REG = 32,
    parameter int unsigned ALLOC_WIDTH  = 2,
    parameter int unsigned FREE_WIDTH   = 2,
    parameter int unsigned NUM_CKPT     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    phys_reg_free_list_ckpt_if.slave   bus
);
    localparam int unsigned PREG_W = $clog2(NUM_PHYS_REG);
    localparam int unsigned CNT_W  = PREG_W + 1;
    localparam int unsigned CKPT_W = $clog2(NUM_CKPT);
    localparam int unsigned PTR_W  = CKPT_W + 1;

    logic [NUM_PHYS_REG-1:0]        fb_q, fb_d;
    logic [NUM_PHYS_REG-1:0]        ckpt_q [NUM_CKPT];
    logic [PTR_W-1:0]               head_q, head_d, tail_q, tail_d;

    logic [NUM_PHYS_REG-1:0]        remain, grant_mask, free_mask, flush_mask;
    logic [ALLOC_WIDTH*PREG_W-1:0]  pick;
    logic                           found;
    logic [CNT_W-1:0]               count;
    logic                           alloc_go, ring_full, ring_empty;
    logic                           save_go, release_go, restore_wrap;

    // k-th lowest set bit of the bitmap for each alloc port
    always_comb begin
        pick       = '0;
        grant_mask = '0;
        remain     = fb_q;
        found      = 1'b0;
        for (int k = 0; k < int'(ALLOC_WIDTH); k++) begin
            found = 1'b0;
            for (int i = 0; i < int'(NUM_PHYS_REG); i++) begin
                if (!found && remain[i]) begin
                    found                      = 1'b1;
                    remain[i]                  = 1'b0;
                    pick[k*PREG_W +: PREG_W]   = PREG_W'(i);
                    grant_mask[i]              = bus.alloc_req[k];
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < int'(NUM_PHYS_REG); i++) begin
            count = count + CNT_W'(fb_q[i]);
        end
    end

    // p0 is pinned to x0 and never returns to the pool
    always_comb begin
        free_mask = '0;
        for (int f = 0; f < int'(FREE_WIDTH); f++) begin
            if (bus.free_valid[f] && (bus.free_preg[f*PREG_W +: PREG_W] != '0)) begin
                free_mask[bus.free_preg[f*PREG_W +: PREG_W]] = 1'b1;
            end
        end
    end

    always_comb begin
        flush_mask = '1;
        for (int a = 0; a < int'(NUM_ARCH_REG); a++) begin
            flush_mask[bus.rrf_map[a*PREG_W +: PREG_W]] = 1'b0;
        end
    end

    assign ring_full  = (head_q[CKPT_W-1:0] == tail_q[CKPT_W-1:0]) &&
                        (head_q[CKPT_W] != tail_q[CKPT_W]);
    assign ring_empty = (head_q == tail_q);
    assign alloc_go   = (count >= CNT_W'(ALLOC_WIDTH));
    assign save_go    = bus.ckpt_save && !ring_full && !bus.flush && !bus.ckpt_restore;
    assign release_go = bus.ckpt_release && !ring_empty && !bus.flush && !bus.ckpt_restore;
    // A valid restore tag lies in [head, tail); it shares head's wrap unless it sits below head's index
    assign restore_wrap = (bus.ckpt_restore_tag >= head_q[CKPT_W-1:0]) ? head_q[CKPT_W]
                                                                        : ~head_q[CKPT_W];

    always_comb begin
        fb_d   = fb_q;
        head_d = head_q;
        tail_d = tail_q;
        if (bus.flush) begin
            fb_d   = flush_mask;
            head_d = '0;
            tail_d = '0;
        end else if (bus.ckpt_restore) begin
            fb_d   = ckpt_q[bus.ckpt_restore_tag] | free_mask;
            tail_d = {restore_wrap, bus.ckpt_restore_tag};
        end else begin
            fb_d = (fb_q & ~(alloc_go ? grant_mask : '0)) | free_mask;
            if (save_go)    tail_d = tail_q + PTR_W'(1);
            if (release_go) head_d = head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_PHYS_REG); i++) begin
                fb_q[i] <= (i >= int'(NUM_ARCH_REG));
            end
            head_q <= '0;
            tail_q <= '0;
        end else begin
            fb_q   <= fb_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Committed frees are older than every branch, so they land in all slots
    always_ff @(posedge clk) begin
        for (int c = 0; c < int'(NUM_CKPT); c++) begin
            if (!bus.flush) begin
                if (save_go && (tail_q[CKPT_W-1:0] == CKPT_W'(c))) begin
                    ckpt_q[c] <= fb_d;
                end else begin
                    ckpt_q[c] <= ckpt_q[c] | free_mask;
                end
            end
        end
    end

    assign bus.alloc_preg  = pick;
    assign bus.alloc_ready = alloc_go;
    assign bus.free_count  = count;
    assign bus.ckpt_tag    = tail_q[CKPT_W-1:0];
    assign bus.ckpt_full   = ring_full;
endmodule

// File: tb/tb_phys_reg_free_list_ckpt.sv
// Directed bench for the checkpointed physical-register free list.
module tb_phys_reg_free_list_ckpt;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    phys_reg_free_list_ckpt_if bus ();

    phys_reg_free_list_ckpt dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.alloc_req        = '0;
        bus.free_valid       = '0;
        bus.free_preg        = '0;
        bus.ckpt_save        = 1'b0;
        bus.ckpt_release     = 1'b0;
        bus.ckpt_restore     = 1'b0;
        bus.ckpt_restore_tag = '0;
        bus.flush            = 1'b0;
        for (int i = 0; i < 32; i++) bus.rrf_map[i*6 +: 6] = 6'(i);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;

        // Reset state
        do_reset();
        check("rst_count", 64'(bus.free_count), 64'd32);
        check("rst_p0", 64'(bus.alloc_preg[5:0]), 64'd32);
        check("rst_p1", 64'(bus.alloc_preg[11:6]), 64'd33);
        check("rst_ready", 64'(bus.alloc_ready), 64'd1);
        check("rst_tag", 64'(bus.ckpt_tag), 64'd0);
        check("rst_full", 64'(bus.ckpt_full), 64'd0);

        // Three back-to-back dual allocations
        bus.alloc_req = 2'b11;
        tick();
        check("a1_count", 64'(bus.free_count), 64'd30);
        check("a1_p0", 64'(bus.alloc_preg[5:0]), 64'd34);
        check("a1_p1", 64'(bus.alloc_preg[11:6]), 64'd35);
        tick();
        check("a2_count", 64'(bus.free_count), 64'd28);
        check("a2_p0", 64'(bus.alloc_preg[5:0]), 64'd36);
        check("a2_p1", 64'(bus.alloc_preg[11:6]), 64'd37);
        tick();
        check("a3_count", 64'(bus.free_count), 64'd26);

        // Port 1 alone takes the second-lowest free preg
        do_reset();
        bus.alloc_req = 2'b10;
        tick();
        bus.alloc_req = 2'b00;
        check("p1only_count", 64'(bus.free_count), 64'd31);
        check("p1only_p0", 64'(bus.alloc_preg[5:0]), 64'd32);
        check("p1only_p1", 64'(bus.alloc_preg[11:6]), 64'd34);

        // Drain to empty, stall, then free and reuse
        do_reset();
        bus.alloc_req = 2'b11;
        repeat (16) tick();
        check("drain_count", 64'(bus.free_count), 64'd0);
        check("drain_ready", 64'(bus.alloc_ready), 64'd0);
        tick();
        check("stall_count", 64'(bus.free_count), 64'd0);
        bus.free_valid = 2'b11;
        bus.free_preg  = {6'd41, 6'd40};
        tick();
        clear_inputs();
        check("refree_p0", 64'(bus.alloc_preg[5:0]), 64'd40);
        check("refree_p1", 64'(bus.alloc_preg[11:6]), 64'd41);
        check("refree_ready", 64'(bus.alloc_ready), 64'd1);
        check("refree_count", 64'(bus.free_count), 64'd2);

        // Free of p0 is ignored
        do_reset();
        bus.free_valid = 2'b01;
        bus.free_preg  = '0;
        tick();
        clear_inputs();
        check("p0_count", 64'(bus.free_count), 64'd32);
        check("p0_p0", 64'(bus.alloc_preg[5:0]), 64'd32);

        // Save, allocate past it, free, then restore
        do_reset();
        bus.alloc_req = 2'b11;
        tick();
        bus.ckpt_save = 1'b1;
        tick();
        bus.ckpt_save = 1'b0;
        check("save_tag", 64'(bus.ckpt_tag), 64'd1);
        bus.free_valid = 2'b01;
        bus.free_preg  = {6'd0, 6'd33};
        tick();
        clear_inputs();
        bus.ckpt_restore = 1'b1;
        bus.alloc_req    = 2'b11;
        tick();
        clear_inputs();
        check("rest_p0", 64'(bus.alloc_preg[5:0]), 64'd33);
        check("rest_p1", 64'(bus.alloc_preg[11:6]), 64'd36);
        check("rest_tag", 64'(bus.ckpt_tag), 64'd0);
        check("rest_count", 64'(bus.free_count), 64'd29);
        check("rest_full", 64'(bus.ckpt_full), 64'd0);

        // Ring fill, overflow save, release, reuse
        do_reset();
        bus.ckpt_release = 1'b1;
        tick();
        bus.ckpt_release = 1'b0;
        bus.ckpt_save    = 1'b1;
        repeat (4) tick();
        check("ring_full", 64'(bus.ckpt_full), 64'd1);
        check("ring_full_tag", 64'(bus.ckpt_tag), 64'd0);
        tick();
        check("ovf_tag", 64'(bus.ckpt_tag), 64'd0);
        check("ovf_full", 64'(bus.ckpt_full), 64'd1);
        bus.ckpt_save    = 1'b0;
        bus.ckpt_release = 1'b1;
        tick();
        bus.ckpt_release = 1'b0;
        check("rel_full", 64'(bus.ckpt_full), 64'd0);
        check("rel_tag", 64'(bus.ckpt_tag), 64'd0);
        bus.ckpt_save = 1'b1;
        tick();
        bus.ckpt_save = 1'b0;
        check("resave_tag", 64'(bus.ckpt_tag), 64'd1);
        check("resave_full", 64'(bus.ckpt_full), 64'd1);

        // Flush with x5->p40; same-cycle free of p40 and everything else dropped
        do_reset();
        bus.alloc_req = 2'b11;
        repeat (5) tick();
        bus.alloc_req = 2'b00;
        bus.ckpt_save = 1'b1;
        tick();
        bus.flush        = 1'b1;
        bus.rrf_map[5*6 +: 6] = 6'd40;
        bus.alloc_req    = 2'b11;
        bus.free_valid   = 2'b11;
        bus.free_preg    = {6'd41, 6'd40};
        bus.ckpt_release = 1'b1;
        tick();
        clear_inputs();
        check("flush_p0", 64'(bus.alloc_preg[5:0]), 64'd5);
        check("flush_p1", 64'(bus.alloc_preg[11:6]), 64'd32);
        check("flush_count", 64'(bus.free_count), 64'd32);
        check("flush_tag", 64'(bus.ckpt_tag), 64'd0);
        check("flush_full", 64'(bus.ckpt_full), 64'd0);
        bus.alloc_req = 2'b11;
        tick();
        bus.alloc_req = 2'b00;
        check("post_flush_p0", 64'(bus.alloc_preg[5:0]), 64'd33);
        check("post_flush_p1", 64'(bus.alloc_preg[11:6]), 64'd34);

        // Free in the same cycle as restore survives the restore
        do_reset();
        bus.alloc_req = 2'b11;
        tick();
        bus.alloc_req = 2'b00;
        bus.ckpt_save = 1'b1;
        tick();
        bus.ckpt_save = 1'b0;
        bus.alloc_req = 2'b11;
        tick();
        bus.ckpt_restore = 1'b1;
        bus.free_valid   = 2'b01;
        bus.free_preg    = {6'd0, 6'd32};
        tick();
        clear_inputs();
        check("rfree_p0", 64'(bus.alloc_preg[5:0]), 64'd32);
        check("rfree_p1", 64'(bus.alloc_preg[11:6]), 64'd34);
        check("rfree_count", 64'(bus.free_count), 64'd31);
        check("rfree_tag", 64'(bus.ckpt_tag), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
